// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings common to the transmitter and receiver,
// the default bit period and the data width.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } uart_state_t;

    // 50 MHz system clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DATA_BITS            = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is
// parameterised so idle-high and idle-low lines can both use it.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Async,
    output logic o_Sync
);

    logic sync_p0;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sync_p0 <= RESET_VAL;
            o_Sync  <= RESET_VAL;
        end else begin
            sync_p0 <= i_Async;
            o_Sync  <= sync_p0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, 8 data bits LSB first, optional even parity
// (define UART_RX_PARITY_EN), one stop bit; good bytes are flagged with o_Rx_DV.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Rx_Active,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state;
    logic [CW-1:0]        count;
    logic [2:0]           index;
    logic [DATA_BITS-1:0] rx_shift;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Async (i_Rx_Serial),
        .o_Sync  (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic parity_bit;
    logic parity_ok;

    // Even parity: data bits plus parity bit must XOR to zero
    assign parity_ok = ~(^{rx_shift, parity_bit});
`else
    logic parity_ok;

    assign parity_ok    = 1'b1;
    assign o_Parity_Err = 1'b0;
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= IDLE;
            count       <= '0;
            index       <= '0;
            rx_shift    <= '0;
            o_Rx_Byte   <= '0;
            o_Rx_DV     <= 1'b0;
            o_Rx_Active <= 1'b0;
            o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit   <= 1'b0;
            o_Parity_Err <= 1'b0;
`endif
        end else begin
            o_Rx_DV     <= 1'b0;
            o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_Parity_Err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    count <= '0;
                    index <= '0;
                    if (!rx_s) begin
                        state       <= START;
                        o_Rx_Active <= 1'b1;
                    end else begin
                        o_Rx_Active <= 1'b0;
                    end
                end

                // Re-check the start bit at mid-bit so short glitches are dropped
                START: begin
                    if (count == HALF) begin
                        count <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state       <= IDLE;
                            o_Rx_Active <= 1'b0;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                DATA: begin
                    if (count == LAST) begin
                        count           <= '0;
                        rx_shift[index] <= rx_s;
                        if (index == LAST_IDX) begin
                            index <= '0;
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            index <= index + 1'b1;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (count == LAST) begin
                        count      <= '0;
                        parity_bit <= rx_s;
                        state      <= STOP;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (count == LAST) begin
                        count <= '0;
                        state <= CLEANUP;
                        if (rx_s && parity_ok) begin
                            o_Rx_DV   <= 1'b1;
                            o_Rx_Byte <= rx_shift;
                        end
                        o_Frame_Err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                        o_Parity_Err <= ~parity_ok;
`endif
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                // A break keeps the line low; wait for idle so it cannot look like a start bit
                CLEANUP: begin
                    if (rx_s) begin
                        state       <= IDLE;
                        o_Rx_Active <= 1'b0;
                    end
                end

                default: begin
                    state       <= IDLE;
                    count       <= '0;
                    index       <= '0;
                    o_Rx_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx at 8 clocks per bit; a serialiser task pushes
// expected events and a negedge monitor pops and compares them.
module tb_uart_rx;

    localparam int C    = 8;
    localparam int H    = (C - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int LAT  = 3 + H + (NBITS - 1) * C;

    typedef struct {
        int         cyc;
        bit         dv;
        bit         fe;
        bit         pe;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pin = 1'b1;
    logic       dv, act, fe, pe;
    logic [7:0] rx_byte;

    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] held = 8'h00;
    exp_t       exp_q[$];

    uart_rx #(
        .CLKS_PER_BIT (C)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Rx_Serial  (pin),
        .o_Rx_DV      (dv),
        .o_Rx_Byte    (rx_byte),
        .o_Rx_Active  (act),
        .o_Frame_Err  (fe),
        .o_Parity_Err (pe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Advance n clock edges, ending just after an edge
    task automatic hold(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serialise one frame; the expected outcome is derived from the frame contents alone
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b, input int gap);
        exp_t e;
        bit   par_ok;
`ifdef UART_RX_PARITY_EN
        par_ok = ((^d) ^ par_b) == 1'b0;
`else
        par_ok = 1'b1;
`endif
        e.cyc  = cyc + 1 + LAT;
        e.dv   = stop_b && par_ok;
        e.fe   = !stop_b;
        e.pe   = !par_ok;
        e.data = d;
        exp_q.push_back(e);
        pin = 1'b0;
        hold(C);
        for (int i = 0; i < 8; i++) begin
            pin = d[i];
            hold(C);
        end
`ifdef UART_RX_PARITY_EN
        pin = par_b;
        hold(C);
`endif
        pin = stop_b;
        hold(C);
        pin = 1'b1;
        hold(gap);
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (dv || fe || pe) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, dv, fe, pe}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("dv", dv, e.dv);
                check("frame_err", fe, e.fe);
                check("parity_err", pe, e.pe);
                if (e.dv) begin
                    check("rx_byte", rx_byte, e.data);
                    held = e.data;
                end else begin
                    check("rx_byte_held", rx_byte, held);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   saw;
        logic [7:0] d;
        logic       sb, pb;
        int         gap;

        hold(5);
        rst = 1'b0;
        hold(1);
        @(negedge clk);
        check("reset_dv", dv, 1'b0);
        check("reset_byte", rx_byte, 8'h00);
        check("reset_active", act, 1'b0);
        check("reset_fe", fe, 1'b0);
        check("reset_pe", pe, 1'b0);
        @(posedge clk);
        #1;

        // Single frame
        send_frame(8'hA5, 1'b1, ^8'hA5, 5);

        // Back-to-back extremes
        send_frame(8'h00, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 10);

        // Two-cycle glitch
        pin = 1'b0;
        hold(2);
        pin = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (act) saw = 1'b1;
        end
        check("glitch_active_seen", saw, 1'b1);
        check("glitch_active_end", act, 1'b0);
        check("glitch_byte", rx_byte, held);
        @(posedge clk);
        #1;

        // Stop bit low followed by a break
        send_frame(8'h3C, 1'b0, ^8'h3C, 0);
        pin = 1'b0;
        hold(40);
        check("break_active", act, 1'b1);
        pin = 1'b1;
        hold(5);
        check("break_released", act, 1'b0);
        send_frame(8'h11, 1'b1, ^8'h11, 4);

        // Reset during data bit 4 of 0x5A
        d = 8'h5A;
        pin = 1'b0;
        hold(C);
        for (int i = 0; i < 4; i++) begin
            pin = d[i];
            hold(C);
        end
        pin = d[4];
        hold(C / 2);
        rst = 1'b1;
        held = 8'h00;
        hold(2);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_dv", dv, 1'b0);
        check("midreset_byte", rx_byte, 8'h00);
        check("midreset_active", act, 1'b0);
        check("midreset_fe", fe, 1'b0);
        @(posedge clk);
        #1;
        pin = 1'b1;
        hold(10);
        send_frame(8'h5A, 1'b1, ^8'h5A, 3);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 3);
        send_frame(8'h07, 1'b1, 1'b0, 3);
`endif

        // Randomised frames
        for (int n = 0; n < 16; n++) begin
            d  = 8'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            pb = ^d;
`ifdef UART_RX_PARITY_EN
            if ($urandom_range(0, 4) == 0) pb = ~pb;
`endif
            gap = sb ? $urandom_range(0, 10) : $urandom_range(2, 8);
            send_frame(d, sb, pb, gap);
        end

        hold(200);
        check("scoreboard_drained", exp_q.size(), 0);
        check("idle_at_end", act, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
